// File: rtl/ysyx_22040632_mcycle_ctrl.sv
// ysyx_22040632_mcycle_ctrl: multi-cycle F/D/E/M/W sequencer for the NPC core.
// Owns PC, instruction register, halt, memory watchdog and retire counter.
module ysyx_22040632_mcycle_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    output logic [63:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    output logic [63:0] pc,
    input  logic [1:0]  op_class,
    input  logic        halt_req,
    input  logic [63:0] next_pc,
    output logic        lsu_req_valid,
    output logic        lsu_req_we,
    input  logic        lsu_rsp_valid,
    output logic        rf_we,
    output logic        halted,
    output logic        timeout_err,
    output logic [63:0] retired
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nx;

    // Low for the cycles reset is held, so FETCH issues nothing until release.
    logic active;

    logic [CW-1:0] wcnt;
    logic tmo_hit;
    logic fetching;
    logic mem_op;

    assign tmo_hit = (wcnt == TMO);
    assign fetching = active && (state == S_FETCH);
    assign mem_op = (op_class == 2'd1) || (op_class == 2'd2);
    assign ifu_req_addr = pc;

    // Next-state selection and Moore outputs from the registered state.
    always_comb begin
        state_nx = state;
        ifu_req_valid = fetching;
        lsu_req_valid = (state == S_MEM);
        lsu_req_we = (state == S_MEM) && (op_class == 2'd2);
        rf_we = (state == S_WB) && (op_class != 2'd2);
        unique case (state)
            S_FETCH: begin
                if (active) begin
                    if (ifu_rsp_valid) begin
                        state_nx = S_DECODE;
                    end else if (tmo_hit) begin
                        state_nx = S_ERR;
                    end
                end
            end
            S_DECODE: state_nx = halt_req ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (lsu_rsp_valid) begin
                    state_nx = S_WB;
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            S_ERR:    state_nx = S_ERR;
            default:  state_nx = S_FETCH;
        endcase
    end

    // State, watchdog, architectural registers and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            active <= 1'b0;
            wcnt <= '0;
            pc <= RESET_PC;
            inst <= 32'd0;
            halted <= 1'b0;
            timeout_err <= 1'b0;
            retired <= 64'd0;
        end else begin
            active <= 1'b1;
            state <= state_nx;
            if (state_nx != state) begin
                wcnt <= '0;
            end else if (fetching || (state == S_MEM)) begin
                wcnt <= wcnt + 1'b1;
            end
            if (fetching && ifu_rsp_valid) begin
                inst <= ifu_rsp_inst;
            end
            if (state == S_WB) begin
                pc <= next_pc;
                retired <= retired + 64'd1;
            end
            if ((state == S_DECODE) && halt_req) begin
                halted <= 1'b1;
            end
            if ((state_nx == S_ERR) && (state != S_ERR)) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_mcycle_ctrl.sv
// tb_ysyx_22040632_mcycle_ctrl: vector table, random programs and corner
// sequences against a transaction-level latency/retire model.
module tb_ysyx_22040632_mcycle_ctrl;

    localparam logic [63:0] RPC = 64'h8000_0000;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid;
    logic [63:0] ifu_req_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst = 32'd0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  op_class = 2'd0;
    logic        halt_req = 1'b0;
    logic [63:0] next_pc = 64'd0;
    logic        lsu_req_valid;
    logic        lsu_req_we;
    logic        lsu_rsp_valid = 1'b0;
    logic        rf_we;
    logic        halted;
    logic        timeout_err;
    logic [63:0] retired;

    int total = 0;
    int bad = 0;
    longint unsigned exp_ret = 0;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  cls;
        logic [63:0] npc;
        int          fw;
        int          mw;
        int          lat;
    } vec_t;

    vec_t vt[6];

    ysyx_22040632_mcycle_ctrl #(
        .RESET_PC(RPC),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst(ifu_rsp_inst),
        .inst(inst),
        .pc(pc),
        .op_class(op_class),
        .halt_req(halt_req),
        .next_pc(next_pc),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_we(lsu_req_we),
        .lsu_rsp_valid(lsu_rsp_valid),
        .rf_we(rf_we),
        .halted(halted),
        .timeout_err(timeout_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Hold reset n cycles, check reset values, release and check first fetch.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        halt_req = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_ret", retired, 64'd0);
        chk("rst_flags", {60'd0, halted, timeout_err, rf_we, lsu_req_valid},
            64'd0);
        chk("rst_ifu", {63'd0, ifu_req_valid}, 64'd0);
        rst_n = 1'b1;
        exp_ret = 0;
        @(posedge clk);
        #1;
        chk("first_fetch", {63'd0, ifu_req_valid}, 64'd1);
        chk("first_addr", ifu_req_addr, RPC);
    endtask

    // One instruction with a reactive memory model; checks latency and effects.
    task automatic run_inst(input logic [31:0] word, input logic [1:0] cls,
                            input logic [63:0] npc, input int fw,
                            input int mw, input int lat);
        int fc = 0;
        int mc = 0;
        int cyc = 0;
        int nrf = 0;
        bit done = 0;
        longint unsigned r0 = retired;
        op_class = cls;
        next_pc = npc;
        halt_req = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (lsu_req_valid) begin
                chk("lsu_we", {63'd0, lsu_req_we}, {63'd0, cls == 2'd2});
            end
            if (rf_we) nrf++;
            if (ifu_req_valid) begin
                ifu_rsp_valid = (fc == fw);
                ifu_rsp_inst = word;
                fc++;
            end else begin
                ifu_rsp_valid = 1'($urandom);
                ifu_rsp_inst = $urandom;
            end
            if (lsu_req_valid) begin
                lsu_rsp_valid = (mc == mw);
                mc++;
            end else begin
                lsu_rsp_valid = 1'($urandom);
            end
            cyc++;
            @(posedge clk);
            #1;
            if (retired != r0) done = 1;
        end
        exp_ret++;
        chk("latency", 64'(cyc), 64'(lat));
        chk("fetch_cyc", 64'(fc), 64'(fw + 1));
        chk("mem_cyc", 64'(mc), (cls == 2'd1 || cls == 2'd2) ? 64'(mw + 1) : 0);
        chk("rf_pulses", 64'(nrf), (cls == 2'd2) ? 64'd0 : 64'd1);
        chk("pc", pc, npc);
        chk("retired", retired, exp_ret);
        chk("inst", {32'd0, inst}, {32'd0, word});
        chk("no_err", {62'd0, timeout_err, halted}, 64'd0);
        chk("next_fetch", {63'd0, ifu_req_valid}, 64'd1);
    endtask

    // Ebreak: halted right after DECODE, nothing retires or issues afterwards.
    task automatic run_halt(input int fw);
        int fc = 0;
        int cyc = 0;
        int viol = 0;
        longint unsigned r0 = retired;
        op_class = 2'd0;
        halt_req = 1'b1;
        while (!halted && cyc < 40) begin
            @(negedge clk);
            ifu_rsp_valid = ifu_req_valid && (fc == fw);
            ifu_rsp_inst = 32'h0010_0073;
            if (ifu_req_valid) fc++;
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("halt_lat", 64'(cyc), 64'(fw + 2));
        chk("halt_ret", retired, r0);
        repeat (20) begin
            @(negedge clk);
            ifu_rsp_valid = 1'($urandom);
            lsu_rsp_valid = 1'($urandom);
            if (ifu_req_valid || lsu_req_valid || rf_we) viol++;
        end
        chk("halt_quiet", 64'(viol), 64'd0);
        chk("halt_sticky", {63'd0, halted}, 64'd1);
        chk("halt_ret2", retired, r0);
    endtask

    // Watchdog expiry in FETCH (in_mem=0) or MEM (in_mem=1).
    task automatic run_tmo(input bit in_mem);
        int rq = 0;
        int cyc = 0;
        int viol = 0;
        logic [63:0] p0 = pc;
        longint unsigned r0 = retired;
        op_class = 2'd1;
        halt_req = 1'b0;
        while (!timeout_err && cyc < 40) begin
            @(negedge clk);
            ifu_rsp_valid = in_mem && ifu_req_valid;
            lsu_rsp_valid = 1'b0;
            if (in_mem ? lsu_req_valid : ifu_req_valid) rq++;
            cyc++;
            @(posedge clk);
            #1;
        end
        chk(in_mem ? "tmo_mem_waits" : "tmo_if_waits", 64'(rq), 64'(TMO + 1));
        chk("tmo_pc", pc, p0);
        chk("tmo_ret", retired, r0);
        repeat (5) begin
            @(negedge clk);
            ifu_rsp_valid = 1'b1;
            lsu_rsp_valid = 1'b1;
            if (ifu_req_valid || lsu_req_valid || rf_we || !timeout_err) viol++;
        end
        chk("tmo_quiet", 64'(viol), 64'd0);
    endtask

    // Reset pulse of one cycle while a load waits in MEM.
    task automatic run_mid_reset();
        int cyc = 0;
        op_class = 2'd1;
        next_pc = 64'h8000_1234;
        halt_req = 1'b0;
        lsu_rsp_valid = 1'b0;
        while (!lsu_req_valid && cyc < 20) begin
            @(negedge clk);
            ifu_rsp_valid = ifu_req_valid;
            ifu_rsp_inst = 32'h0000_3083;
            lsu_rsp_valid = 1'b0;
            cyc++;
        end
        chk("mid_in_mem", {63'd0, lsu_req_valid}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_pc", pc, RPC);
        chk("mid_outs", {61'd0, lsu_req_valid, rf_we, ifu_req_valid}, 64'd0);
        chk("mid_ret", retired, 64'd0);
        rst_n = 1'b1;
        exp_ret = 0;
        @(posedge clk);
        #1;
        chk("mid_fetch", {63'd0, ifu_req_valid}, 64'd1);
    endtask

    initial begin
        vt[0] = '{32'h0010_0093, 2'd0, 64'h8000_0004, 0, 0, 4};
        vt[1] = '{32'h0000_3083, 2'd1, 64'h8000_0008, 0, 3, 8};
        vt[2] = '{32'h0010_3023, 2'd2, 64'h8000_000c, 0, 0, 5};
        vt[3] = '{32'h0080_006f, 2'd3, 64'h8000_0100, 2, 0, 6};
        vt[4] = '{32'h0040_3103, 2'd1, 64'h8000_0104, 4, 4, 13};
        vt[5] = '{32'h0020_3423, 2'd2, 64'h8000_0108, 1, 2, 8};

        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            run_inst(vt[i].word, vt[i].cls, vt[i].npc, vt[i].fw, vt[i].mw,
                     vt[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] c;
            int f;
            int m;
            int l;
            logic [63:0] np;
            c = 2'($urandom_range(0, 3));
            f = $urandom_range(0, TMO);
            m = $urandom_range(0, TMO);
            np = {$urandom, $urandom} & ~64'd3;
            l = 4 + f + ((c == 2'd1 || c == 2'd2) ? m + 1 : 0);
            run_inst($urandom, c, np, f, m, l);
        end

        run_halt(1);
        do_reset(2);
        run_inst(32'h0010_0093, 2'd0, 64'h8000_0004, 0, 0, 4);
        run_tmo(1'b0);
        do_reset(1);
        run_tmo(1'b1);
        do_reset(2);
        run_inst(32'h0080_006f, 2'd3, 64'h8000_0040, 3, 0, 7);
        run_mid_reset();
        run_inst(32'h0010_0093, 2'd0, 64'h8000_0004, 0, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
